serial_spi_buffer: RTL and testbench
====================================

# serial_spi_buffer

Parametrised synchronous circular buffer that replaces the fixed 32-byte load-once store in the Serial-to-SPI bridge. It sits between the UART receive path (writer) and the SPI transmit sequencer (reader). It adds true FIFO pop semantics, random-access peek relative to the head, a flush, an early-warning CTS margin, and optional sticky error flags. All storage and control are clocked by a single clock; there are no edge-triggered strobes.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 32, entries; power of two, ≥4
- CTS_MARGIN, 4, free slots required to keep CTS asserted; 1..DEPTH
- AW (localparam), log2(DEPTH), pointer/address width

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- LOAD  in  1  write strobe, one word per cycle while high
- BYTEIN  in  WIDTH  write data
- READ  in  1  pop strobe
- PEEK  in  1  non-destructive read at head+ADDR
- ADDR  in  AW  peek offset from head
- CLEAR  in  1  synchronous flush
- RTS  in  1  upstream request-to-send
- CTS  out  1  clear-to-send
- BYTEOUT  out  WIDTH  registered read data
- VALID  out  1  BYTEOUT updated this cycle (1-cycle pulse)
- FULL  out  1  COUNT==DEPTH
- EMPTY  out  1  COUNT==0
- COUNT  out  AW+1  occupied entries, 0..DEPTH
- OVF  out  1  sticky overflow (see Configuration)
- UDF  out  1  sticky underflow (see Configuration)

## Operation
- State: wr_ptr, rd_ptr (AW bits, wrap modulo DEPTH naturally), COUNT (AW+1 bits), mem[DEPTH].
- Write accepted iff LOAD && !FULL: mem[wr_ptr]<=BYTEIN, wr_ptr++. LOAD while FULL is dropped, even if READ is active in the same cycle.
- Pop accepted iff READ && !EMPTY: BYTEOUT<=mem[rd_ptr], rd_ptr++, VALID=1 next cycle. READ while EMPTY is dropped, even if LOAD is active in the same cycle. There is no write-through bypass.
- Peek when PEEK && !READ:
  - ADDR<COUNT: BYTEOUT<=mem[(rd_ptr+ADDR) mod DEPTH], VALID=1. Pointers unchanged.
  - ADDR≥COUNT: no effect, VALID=0.
- READ has priority over PEEK.
- COUNT: +1 on write only, -1 on pop only, unchanged when both are accepted.
- CLEAR: wr_ptr, rd_ptr and COUNT go to 0; VALID=0. LOAD, READ and PEEK are ignored that cycle. mem and BYTEOUT are retained. CLEAR does not clear OVF/UDF.
- CTS = RTS && (DEPTH-COUNT ≥ CTS_MARGIN). Combinational from registered COUNT.
- FULL and EMPTY are decoded from registered COUNT.

## Timing
- Reset values: BYTEOUT=0, VALID=0, COUNT=0, EMPTY=1, FULL=0, OVF=0, UDF=0, pointers 0. CTS follows RTS (CTS_MARGIN≤DEPTH).
- Reset asserted mid-operation aborts immediately and discards contents logically. mem contents are not reset.
- Write latency: an entry written at edge N is visible to pop or peek at edge N+1. COUNT/FULL/EMPTY update at edge N.
- Read latency: 1 cycle. BYTEOUT and VALID are valid after the edge that samples READ/PEEK.
- Throughput: one write and one pop per cycle, sustained.
- CTS drops in the same cycle COUNT reaches DEPTH-CTS_MARGIN+1. The writer may still deliver CTS_MARGIN-1 in-flight words without loss.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.

## Configuration
- SERIAL_SPI_BUFFER_ERR_EN defined:
  - OVF sets on any LOAD while FULL (and not CLEAR).
  - UDF sets on any READ while EMPTY (and not CLEAR).
  - Both stay set until RESET.
- Undefined: OVF and UDF are tied 0; no flag registers are synthesised.
- Data-path behaviour is identical in both builds.

## Test plan
- Reset, then 32 LOADs of 0x00..0x1F (DEPTH=32) -> FULL=1 after the 32nd edge, COUNT=32. A 33rd LOAD of 0xAA is dropped, OVF=1 (macro on) or 0 (off).
- From full, 32 READs -> BYTEOUT sequence 0x00..0x1F, each with VALID the following cycle. EMPTY=1 at the end. An extra READ gives VALID=0 and UDF=1 (macro on).
- With RTS=1 and CTS_MARGIN=4: load 28 words -> CTS=1. The 29th write drops CTS to 0; it returns to 1 after one pop.
- Write 20, pop 20, then write 20 more (wraps at 32) with simultaneous LOAD+READ for 10 cycles -> COUNT stays 20, output order preserved across the wrap.
- Load 0x10..0x14, PEEK ADDR=3 -> BYTEOUT=0x13, VALID=1, COUNT=5. PEEK ADDR=5 -> VALID=0, BYTEOUT stays 0x13.
- COUNT=7, then CLEAR together with LOAD -> COUNT=0 and EMPTY=1 next cycle, LOAD ignored, BYTEOUT unchanged. Asserting RESET mid-burst forces all outputs to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/serial_spi_buffer_if.sv
// Writer/reader bundle for the serial-to-SPI circular buffer.
// master drives strobes and data; slave is the buffer itself.
interface serial_spi_buffer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             LOAD;
    logic [WIDTH-1:0] BYTEIN;
    logic             READ;
    logic             PEEK;
    logic [AW-1:0]    ADDR;
    logic             CLEAR;
    logic             RTS;
    logic             CTS;
    logic [WIDTH-1:0] BYTEOUT;
    logic             VALID;
    logic             FULL;
    logic             EMPTY;
    logic [AW:0]      COUNT;
    logic             OVF;
    logic             UDF;

    modport master (
        output LOAD, BYTEIN, READ, PEEK, ADDR, CLEAR, RTS,
        input  CTS, BYTEOUT, VALID, FULL, EMPTY, COUNT, OVF, UDF
    );

    modport slave (
        input  LOAD, BYTEIN, READ, PEEK, ADDR, CLEAR, RTS,
        output CTS, BYTEOUT, VALID, FULL, EMPTY, COUNT, OVF, UDF
    );
endinterface

// File: rtl/serial_spi_buffer.sv
// Circular FIFO between UART rx and SPI tx with pop, peek, flush and CTS margin.
// Define SERIAL_SPI_BUFFER_ERR_EN to build the sticky OVF/UDF flags.
module serial_spi_buffer #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int CTS_MARGIN = 4
) (
    input logic                CLK,
    input logic                RESET,
    serial_spi_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_MARGIN = (AW+1)'(CTS_MARGIN);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_byteout;
    logic             r_valid;

    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;
    logic             w_pk;
    logic [AW-1:0]    w_raddr;
    logic [AW:0]      w_free;

    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_free  = LP_DEPTH - r_count;

    assign w_wr = bus.LOAD && !w_full && !bus.CLEAR;
    assign w_rd = bus.READ && !w_empty && !bus.CLEAR;
    // READ wins over PEEK even when the pop itself is dropped
    assign w_pk = bus.PEEK && !bus.READ && !bus.CLEAR
               && ({1'b0, bus.ADDR} < r_count);

    assign w_raddr = w_rd ? r_rd_ptr : r_rd_ptr + bus.ADDR;

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.BYTEIN;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_byteout <= '0;
            r_valid   <= 1'b0;
        end else if (bus.CLEAR) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            r_valid <= w_rd || w_pk;
            if (w_rd || w_pk) begin
                r_byteout <= r_mem[w_raddr];
            end
        end
    end

`ifdef SERIAL_SPI_BUFFER_ERR_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (!bus.CLEAR) begin
            if (bus.LOAD && w_full) begin
                r_ovf <= 1'b1;
            end
            if (bus.READ && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign bus.OVF = r_ovf;
    assign bus.UDF = r_udf;
`else
    assign bus.OVF = 1'b0;
    assign bus.UDF = 1'b0;
`endif

    assign bus.CTS     = bus.RTS && (w_free >= LP_MARGIN);
    assign bus.BYTEOUT = r_byteout;
    assign bus.VALID   = r_valid;
    assign bus.FULL    = w_full;
    assign bus.EMPTY   = w_empty;
    assign bus.COUNT   = r_count;
endmodule

// File: tb/tb_serial_spi_buffer.sv
// Self-checking bench for serial_spi_buffer: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_serial_spi_buffer;
    localparam int DEPTH = 32;

    logic CLK;
    logic RESET;

    serial_spi_buffer_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

    serial_spi_buffer #(
        .WIDTH(8),
        .DEPTH(DEPTH),
        .CTS_MARGIN(4)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_run;
    int n_fail;

    logic [7:0] q[$];
    logic [7:0] m_bo;
    logic       m_vld;
    logic       m_ovf;
    logic       m_udf;
    logic       rts;

    typedef struct {
        logic       ld;
        logic [7:0] din;
        logic       rd;
        logic       pk;
        logic [4:0] addr;
        logic       clr;
        logic [5:0] e_cnt;
        logic       e_vld;
        logic [7:0] e_bo;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_bo  = 8'h00;
        m_vld = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_edge(input logic ld, input logic [7:0] din,
                              input logic rd, input logic pk,
                              input logic [4:0] addr, input logic clr);
        int sz;
        sz = q.size();
        if (clr) begin
            q.delete();
            m_vld = 1'b0;
        end else begin
            if (ld && sz == DEPTH) m_ovf = 1'b1;
            if (rd && sz == 0) m_udf = 1'b1;
            if (rd && sz > 0) begin
                m_bo  = q.pop_front();
                m_vld = 1'b1;
            end else if (pk && !rd && int'(addr) < sz) begin
                m_bo  = q[addr];
                m_vld = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
            if (ld && sz < DEPTH) q.push_back(din);
        end
    endtask

    task automatic check_model(input string tag);
        logic exp_cts;
        exp_cts = rts && ((DEPTH - q.size()) >= 4);
        chk({tag, ".count"}, 32'(bus.COUNT), 32'(q.size()));
        chk({tag, ".full"}, 32'(bus.FULL), 32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(bus.EMPTY), 32'(q.size() == 0));
        chk({tag, ".cts"}, 32'(bus.CTS), 32'(exp_cts));
        chk({tag, ".valid"}, 32'(bus.VALID), 32'(m_vld));
        chk({tag, ".byteout"}, 32'(bus.BYTEOUT), 32'(m_bo));
`ifdef SERIAL_SPI_BUFFER_ERR_EN
        chk({tag, ".ovf"}, 32'(bus.OVF), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(bus.UDF), 32'(m_udf));
`else
        chk({tag, ".ovf"}, 32'(bus.OVF), 32'(0));
        chk({tag, ".udf"}, 32'(bus.UDF), 32'(0));
`endif
    endtask

    task automatic step(input string tag, input logic ld,
                        input logic [7:0] din, input logic rd,
                        input logic pk, input logic [4:0] addr,
                        input logic clr);
        bus.LOAD   = ld;
        bus.BYTEIN = din;
        bus.READ   = rd;
        bus.PEEK   = pk;
        bus.ADDR   = addr;
        bus.CLEAR  = clr;
        bus.RTS    = rts;
        @(posedge CLK);
        model_edge(ld, din, rd, pk, addr, clr);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        #1;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        logic [7:0] bo_hold;
        n_run  = 0;
        n_fail = 0;
        rts    = 1'b1;
        RESET  = 1'b0;
        bus.LOAD = 0; bus.BYTEIN = 0; bus.READ = 0; bus.PEEK = 0;
        bus.ADDR = 0; bus.CLEAR = 0; bus.RTS = 1'b1;
        model_reset();
        #2;
        chk("rst.count", 32'(bus.COUNT), 32'(0));
        chk("rst.empty", 32'(bus.EMPTY), 32'(1));
        chk("rst.full", 32'(bus.FULL), 32'(0));
        chk("rst.valid", 32'(bus.VALID), 32'(0));
        chk("rst.byteout", 32'(bus.BYTEOUT), 32'(0));
        chk("rst.cts", 32'(bus.CTS), 32'(1));
        chk("rst.ovf", 32'(bus.OVF), 32'(0));
        chk("rst.udf", 32'(bus.UDF), 32'(0));
        @(negedge CLK);
        RESET = 1'b1;

        // peek/pop/clear vector table
        tv[0] = '{1, 8'h10, 0, 0, 0, 0, 1, 0, 8'h00};
        tv[1] = '{1, 8'h11, 0, 0, 0, 0, 2, 0, 8'h00};
        tv[2] = '{1, 8'h12, 0, 0, 0, 0, 3, 0, 8'h00};
        tv[3] = '{1, 8'h13, 0, 0, 0, 0, 4, 0, 8'h00};
        tv[4] = '{1, 8'h14, 0, 0, 0, 0, 5, 0, 8'h00};
        tv[5] = '{0, 8'h00, 0, 1, 3, 0, 5, 1, 8'h13};
        tv[6] = '{0, 8'h00, 0, 1, 5, 0, 5, 0, 8'h13};
        tv[7] = '{0, 8'h00, 1, 1, 2, 0, 4, 1, 8'h10};
        tv[8] = '{1, 8'h77, 0, 0, 0, 1, 0, 0, 8'h10};
        for (int i = 0; i < 9; i++) begin
            step("tv", tv[i].ld, tv[i].din, tv[i].rd, tv[i].pk,
                 tv[i].addr, tv[i].clr);
            chk($sformatf("tv%0d.count", i), 32'(bus.COUNT), 32'(tv[i].e_cnt));
            chk($sformatf("tv%0d.valid", i), 32'(bus.VALID), 32'(tv[i].e_vld));
            chk($sformatf("tv%0d.byteout", i), 32'(bus.BYTEOUT), 32'(tv[i].e_bo));
        end

        // fill to full, overflow attempt
        for (int i = 0; i < 32; i++) step("fill", 1, 8'(i), 0, 0, 0, 0);
        chk("fill.full", 32'(bus.FULL), 32'(1));
        chk("fill.count32", 32'(bus.COUNT), 32'(32));
        step("ovf", 1, 8'hAA, 1, 0, 0, 0);
        chk("ovf.count", 32'(bus.COUNT), 32'(31));
        chk("ovf.first", 32'(bus.BYTEOUT), 32'(8'h00));
        for (int i = 1; i < 32; i++) begin
            step("drain", 0, 0, 1, 0, 0, 0);
            chk("drain.seq", 32'(bus.BYTEOUT), 32'(i));
        end
        chk("drain.empty", 32'(bus.EMPTY), 32'(1));
        step("udf", 0, 0, 1, 0, 0, 0);
        chk("udf.valid", 32'(bus.VALID), 32'(0));

        // CTS margin
        step("clr", 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 28; i++) step("cts", 1, 8'(i + 64), 0, 0, 0, 0);
        chk("cts.28", 32'(bus.CTS), 32'(1));
        step("cts29", 1, 8'h5C, 0, 0, 0, 0);
        chk("cts.29", 32'(bus.CTS), 32'(0));
        step("ctspop", 0, 0, 1, 0, 0, 0);
        chk("cts.pop", 32'(bus.CTS), 32'(1));

        // wrap with concurrent load+read
        step("clr", 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step("w20", 1, 8'(i), 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("p20", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("w20b", 1, 8'(i + 100), 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step("lr", 1, 8'(i + 200), 1, 0, 0, 0);
            chk("lr.count", 32'(bus.COUNT), 32'(20));
            chk("lr.order", 32'(bus.BYTEOUT), 32'(i + 100));
        end
        for (int i = 0; i < 20; i++) step("wdrain", 0, 0, 1, 0, 0, 0);

        // clear with load at count 7
        for (int i = 0; i < 7; i++) step("c7", 1, 8'(i + 48), 0, 0, 0, 0);
        bo_hold = m_bo;
        step("clrld", 1, 8'hEE, 0, 0, 0, 1);
        chk("clrld.count", 32'(bus.COUNT), 32'(0));
        chk("clrld.empty", 32'(bus.EMPTY), 32'(1));
        chk("clrld.byteout", 32'(bus.BYTEOUT), 32'(bo_hold));

        // asynchronous reset mid-burst
        for (int i = 0; i < 6; i++) step("burst", 1, 8'(i), i > 2, 0, 0, 0);
        #2;
        RESET = 1'b0;
        #1;
        chk("arst.count", 32'(bus.COUNT), 32'(0));
        chk("arst.valid", 32'(bus.VALID), 32'(0));
        chk("arst.byteout", 32'(bus.BYTEOUT), 32'(0));
        chk("arst.empty", 32'(bus.EMPTY), 32'(1));
        chk("arst.ovf", 32'(bus.OVF), 32'(0));
        chk("arst.udf", 32'(bus.UDF), 32'(0));
        model_reset();
        bus.LOAD = 0; bus.READ = 0; bus.PEEK = 0; bus.CLEAR = 0;
        @(negedge CLK);
        RESET = 1'b1;

        // randomized traffic: load-heavy then read-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int lp;
            lp = (i % 600) < 300 ? 70 : 30;
            if (i % 50 == 0) rts = 1'($urandom_range(0, 1));
            step("rnd",
                 $urandom_range(0, 99) < lp,
                 8'($urandom),
                 $urandom_range(0, 99) < (100 - lp),
                 $urandom_range(0, 99) < 25,
                 5'($urandom),
                 $urandom_range(0, 99) < 2);
            if (i == 1500) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
